weight_fetch_ctrl: RTL and testbench
====================================

Name: weight_fetch_ctrl

Overview:
- Sequences the shared 256x8 weights ROM for one layer pass.
- Walks a configured address window as neurons x inputs.
- Issues one ROM address per cycle and streams the returned signed Q-format weights to the MAC array over a valid/ready handshake, with per-neuron and end-of-layer tags.
- Sits between the layer scheduler (start/done) and the ROM + MAC datapath.

Parameters:
- N, 8, weight word width (matches ROM word).
- Q, 7, fractional bits; passed through only, no arithmetic on weights.
- ADDR_W, 8, ROM address width; 256-entry ROM.
- CNT_W, 8, width of the neuron and input count fields.

Ports:
- clk  in  1  system clock; ROM samples address on falling edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current pass.
- cfg_base  in  ADDR_W  first ROM address of the layer.
- cfg_inputs  in  CNT_W  weights per neuron.
- cfg_neurons  in  CNT_W  neurons in the layer.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse after the final beat handshakes.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  N  signed ROM output, valid at the posedge after rom_addr changes.
- w_data  out  N  signed weight to the MAC.
- w_valid  out  1  w_data valid.
- w_ready  in  1  MAC accepts the beat.
- w_last_in  out  1  beat is the last input of the current neuron.
- w_last  out  1  beat is the final beat of the layer.

Behaviour:
- Reset values: busy=0, done=0, rom_addr=0, w_valid=0, w_data=0, w_last_in=0, w_last=0; FIFO empty; in-flight flag=0; state IDLE.
- Config is latched when start is accepted; later cfg changes have no effect until the next pass.
- IDLE: start=1 with both counts nonzero -> RUN, busy=1, address=cfg_base.
- IDLE: start=1 with either count zero -> done pulses at the next edge, busy stays 0, no beats, state stays IDLE.
- RUN: one read issued per cycle while (FIFO count + in-flight - pop this cycle) < 2.
  - Each issue increments the address modulo 256 (255 wraps to 0) and advances the input/neuron counters.
  - Tags (last_in, last) travel with the in-flight read.
  - Once the last address is issued -> DRAIN.
- ROM latency is one clk: data is captured into the 2-entry FIFO at the posedge after issue, together with its tags.
- DRAIN: no further issues. When the FIFO and in-flight are empty after the w_last handshake -> IDLE, done=1 for one cycle, busy=0.
- Output side: w_* come from the FIFO head. A beat completes when w_valid and w_ready are both high. w_data and the tags are held stable while w_valid=1 and w_ready=0.
- Throughput: with w_ready held high, 1 beat/cycle. The first w_valid is asserted 2 edges after the start edge.
- Backpressure: with w_ready low, at most 2 beats are buffered and no ROM read is lost or duplicated.
- Tags: w_last_in=1 on every cfg_inputs-th beat. w_last=1 only on beat cfg_inputs*cfg_neurons, and w_last_in is also 1 on that beat.
- Counting: total beats = cfg_inputs*cfg_neurons (max 65025). The address window may exceed 256 entries and then wraps modulo 256.
- start while busy: ignored.
- abort (any state): next edge -> IDLE, FIFO flushed, in-flight discarded, w_valid=0, busy=0, no done. abort and start in the same cycle: abort wins.
- rst_n asserted mid-pass: all state returns to reset values immediately; no done.

Decomposition:
- Shared package nar_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - constants WEIGHT_W=8, WEIGHT_Q=7, ROM_ADDR_W=8, ROM_DEPTH=256;
  - tagged weight beat struct {data, last_in, last}.
- One sub-module: weight_skid_fifo, a 2-entry FIFO of tagged beats with count output, using the same clk and rst_n.

Test Plan:
- base=0x10, inputs=3, neurons=2, w_ready=1 -> 6 beats from addresses 0x10..0x15 in consecutive cycles; w_last_in on beats 3 and 6; w_last on beat 6; done 1 cycle after beat 6; busy low with done.
- base=0xFE, inputs=4, neurons=1 -> addresses FE, FF, 00, 01; data matches ROM contents; w_last on the 4th beat.
- inputs=4, neurons=2, w_ready toggled 1,0,0,1 repeating -> all 8 beats in order, none dropped or duplicated, w_data stable during stalls, FIFO never exceeds 2.
- cfg_neurons=0 with start -> done pulse next cycle, w_valid never asserted, busy stays 0.
- Pass started, abort after 3 beats -> next edge IDLE, w_valid=0, no done; a new start then runs a full clean pass.
- rst_n dropped mid-pass while w_ready=0 -> all outputs at reset values immediately; start after release behaves as the first scenario.

Source files
------------

// File: rtl/nar_pkg.sv
// Shared types and constants for the neural accelerator weight path.
package nar_pkg;

  localparam int unsigned WEIGHT_W   = 8;
  localparam int unsigned WEIGHT_Q   = 7;
  localparam int unsigned ROM_ADDR_W = 8;
  localparam int unsigned ROM_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One weight beat with its neuron / layer boundary tags.
  typedef struct packed {
    logic signed [WEIGHT_W-1:0] data;
    logic                       last_in;
    logic                       last;
  } weight_beat_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO of tagged weight beats; head is held in a flop so it drives
// the MAC side directly and stays stable while stalled.
module weight_skid_fifo
  import nar_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  weight_beat_t push_beat,
  input  logic         pop,
  input  logic         flush,
  output weight_beat_t head,
  output logic         head_valid,
  output logic [1:0]   count_c
);

  weight_beat_t e0_q, e0_d;
  weight_beat_t e1_q, e1_d;
  logic         v0_q, v0_d;
  logic         v1_q, v1_d;
  logic         pop_ok_c;
  logic         push_ok_c;

  // Entry 1 is only ever valid when the head is valid.
  assign count_c    = {v1_q, v0_q & ~v1_q};
  assign head       = e0_q;
  assign head_valid = v0_q;
  assign pop_ok_c   = pop & v0_q;
  assign push_ok_c  = push & (~v1_q | pop_ok_c);

  // Next-state for storage: shift on pop, fill lowest free slot on push.
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else begin
      case ({push_ok_c, pop_ok_c})
        2'b10: begin
          if (!v0_q) begin
            e0_d = push_beat;
            v0_d = 1'b1;
          end else begin
            e1_d = push_beat;
            v1_d = 1'b1;
          end
        end
        2'b01: begin
          e0_d = e1_q;
          v0_d = v1_q;
          v1_d = 1'b0;
        end
        2'b11: begin
          if (v1_q) begin
            e0_d = e1_q;
            e1_d = push_beat;
          end else begin
            e0_d = push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Walks the weights ROM window for one layer pass (neurons x inputs) and
// streams tagged weights to the MAC array over valid/ready.
module weight_fetch_ctrl
  import nar_pkg::*;
#(
  parameter int unsigned N      = WEIGHT_W,
  parameter int unsigned Q      = WEIGHT_Q,
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [CNT_W-1:0]    cfg_inputs,
  input  logic [CNT_W-1:0]    cfg_neurons,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic signed [N-1:0] rom_data,
  output logic signed [N-1:0] w_data,
  output logic                w_valid,
  input  logic                w_ready,
  output logic                w_last_in,
  output logic                w_last
);

  // The beat struct is fixed to the ROM word; reject mismatched builds.
  if ((N != WEIGHT_W) || (Q >= N) || ((1 << ADDR_W) != ROM_DEPTH)) begin : g_bad_cfg
    $error("weight_fetch_ctrl: unsupported N/Q/ADDR_W");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  neu_cnt_q, neu_cnt_d;
  logic [CNT_W-1:0]  inputs_q, inputs_d;
  logic [CNT_W-1:0]  neurons_q, neurons_d;
  logic              inflight_q, inflight_d;
  logic              tag_last_in_q, tag_last_in_d;
  logic              tag_last_q, tag_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  weight_beat_t      push_beat_c;
  weight_beat_t      head_c;
  logic              head_valid_c;
  logic [1:0]        fifo_count_c;
  logic              pop_c;
  logic              push_c;
  logic [1:0]        occ_c;
  logic              issue_c;
  logic              last_in_c;
  logic              last_c;

  assign pop_c     = head_valid_c & w_ready;
  assign push_c    = inflight_q & ~abort;
  // Occupancy after this cycle's pop; pop implies count >= 1 so no underflow.
  assign occ_c     = fifo_count_c + 2'(inflight_q) - 2'(pop_c);
  assign issue_c   = (state_q == RUN) && (occ_c < 2'd2) && !abort;
  assign last_in_c = (in_cnt_q == (inputs_q - CNT_W'(1)));
  assign last_c    = last_in_c && (neu_cnt_q == (neurons_q - CNT_W'(1)));

  assign push_beat_c = '{data: WEIGHT_W'(rom_data), last_in: tag_last_in_q, last: tag_last_q};

  weight_skid_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .push_beat  (push_beat_c),
    .pop        (pop_c),
    .flush      (abort),
    .head       (head_c),
    .head_valid (head_valid_c),
    .count_c    (fifo_count_c)
  );

  // Pass sequencing: start/config latch, read issue with tags, drain, abort.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rom_addr_d    = rom_addr_q;
    in_cnt_d      = in_cnt_q;
    neu_cnt_d     = neu_cnt_q;
    inputs_d      = inputs_q;
    neurons_d     = neurons_q;
    inflight_d    = 1'b0;
    tag_last_in_d = tag_last_in_q;
    tag_last_d    = tag_last_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          inputs_d  = cfg_inputs;
          neurons_d = cfg_neurons;
          if ((cfg_inputs == '0) || (cfg_neurons == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            busy_d     = 1'b1;
            addr_d     = cfg_base;
            rom_addr_d = cfg_base;
            in_cnt_d   = '0;
            neu_cnt_d  = '0;
          end
        end
      end
      RUN: begin
        if (issue_c) begin
          rom_addr_d    = addr_q;
          addr_d        = addr_q + ADDR_W'(1);
          inflight_d    = 1'b1;
          tag_last_in_d = last_in_c;
          tag_last_d    = last_c;
          if (last_in_c) begin
            in_cnt_d  = '0;
            neu_cnt_d = neu_cnt_q + CNT_W'(1);
          end else begin
            in_cnt_d  = in_cnt_q + CNT_W'(1);
          end
          if (last_c) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop_c && head_c.last && (fifo_count_c == 2'd1) && !inflight_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      inflight_d = 1'b0;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rom_addr_q    <= '0;
      in_cnt_q      <= '0;
      neu_cnt_q     <= '0;
      inputs_q      <= '0;
      neurons_q     <= '0;
      inflight_q    <= 1'b0;
      tag_last_in_q <= 1'b0;
      tag_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rom_addr_q    <= rom_addr_d;
      in_cnt_q      <= in_cnt_d;
      neu_cnt_q     <= neu_cnt_d;
      inputs_q      <= inputs_d;
      neurons_q     <= neurons_d;
      inflight_q    <= inflight_d;
      tag_last_in_q <= tag_last_in_d;
      tag_last_q    <= tag_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign w_valid   = head_valid_c;
  assign w_data    = N'(head_c.data);
  assign w_last_in = head_c.last_in;
  assign w_last    = head_c.last;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: table of layer passes plus
// abort and mid-pass reset sequences; beats checked against a scoreboard.
module tb_weight_fetch_ctrl;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        cfg_base = '0;
  logic [7:0]        cfg_inputs = '0;
  logic [7:0]        cfg_neurons = '0;
  logic              busy;
  logic              done;
  logic [7:0]        rom_addr;
  logic signed [7:0] rom_data = '0;
  logic signed [7:0] w_data;
  logic              w_valid;
  logic              w_ready = 1'b0;
  logic              w_last_in;
  logic              w_last;

  weight_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_base    (cfg_base),
    .cfg_inputs  (cfg_inputs),
    .cfg_neurons (cfg_neurons),
    .busy        (busy),
    .done        (done),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_last_in   (w_last_in),
    .w_last      (w_last)
  );

  always #5 clk = ~clk;

  // ROM model: samples address on the falling edge.
  logic [7:0] rom [256];
  always @(negedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [7:0] data;
    logic       last_in;
    logic       last;
  } exp_beat_t;

  typedef struct {
    logic [7:0] base;
    logic [7:0] inputs;
    logic [7:0] neurons;
    int         ready_mode;
    int         exp_beats;
    logic [7:0] exp_final_addr;
  } vec_t;

  exp_beat_t exp_q[$];
  vec_t      vecs[7];
  int        n_checks = 0;
  int        n_errors = 0;
  int        beats_seen = 0;
  bit        last_hs = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 2) return 1'b0;
    return ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endfunction

  // Beat monitor: scoreboard pop on handshake, stability check while stalled.
  logic [7:0] hold_data;
  logic       hold_li;
  logic       hold_l;
  bit         stalled = 0;
  always @(negedge clk) begin
    exp_beat_t e;
    if (rst_n && w_valid && stalled) begin
      check("stall_data", 32'($unsigned(w_data)), 32'(hold_data));
      check("stall_last_in", 32'(w_last_in), 32'(hold_li));
      check("stall_last", 32'(w_last), 32'(hold_l));
    end
    stalled   = rst_n && w_valid && !w_ready;
    hold_data = $unsigned(w_data);
    hold_li   = w_last_in;
    hold_l    = w_last;
    if (rst_n && w_valid && w_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got data %0d with no beat expected", w_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 32'($unsigned(w_data)), 32'(e.data));
        check("beat_last_in", 32'(w_last_in), 32'(e.last_in));
        check("beat_last", 32'(w_last), 32'(e.last));
      end
      beats_seen++;
      if (w_last) last_hs = 1;
    end
  end

  task automatic load_expected(input vec_t v);
    logic [7:0] a;
    exp_beat_t  e;
    exp_q.delete();
    for (int n = 0; n < int'(v.neurons); n++) begin
      for (int i = 0; i < int'(v.inputs); i++) begin
        a = 8'(int'(v.base) + n * int'(v.inputs) + i);
        e.data    = rom[a];
        e.last_in = (i == int'(v.inputs) - 1);
        e.last    = e.last_in && (n == int'(v.neurons) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Issue start, then scramble cfg to confirm it was latched.
  task automatic kick(input vec_t v);
    @(posedge clk); #1;
    cfg_base    = v.base;
    cfg_inputs  = v.inputs;
    cfg_neurons = v.neurons;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    cfg_base    = 8'($urandom);
    cfg_inputs  = 8'($urandom_range(1, 9));
    cfg_neurons = 8'($urandom_range(1, 9));
  endtask

  task automatic run_pass(input string tag, input vec_t v);
    int cyc;
    int first_valid;
    bit finished;
    bit any_valid;
    load_expected(v);
    last_hs    = 0;
    beats_seen = 0;
    w_ready    = ready_for(v.ready_mode, 0);
    kick(v);
    if (v.exp_beats == 0) begin
      check({tag, "_zero_done"}, 32'(done), 1);
      check({tag, "_zero_busy"}, 32'(busy), 0);
      any_valid = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (w_valid || busy || done) any_valid = 1;
      end
      check({tag, "_zero_quiet"}, 32'(any_valid), 0);
      check({tag, "_zero_beats"}, beats_seen, 0);
      return;
    end
    cyc = 0;
    first_valid = -1;
    finished = 0;
    check({tag, "_busy_start"}, 32'(busy), 1);
    while (!finished && cyc < 600) begin
      if (w_valid && first_valid < 0) first_valid = cyc;
      if (last_hs) begin
        check({tag, "_done_after_last"}, 32'(done), 1);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        check({tag, "_final_addr"}, 32'(rom_addr), 32'(v.exp_final_addr));
        finished = 1;
      end else if (done) begin
        check({tag, "_early_done"}, 32'(done), 0);
        finished = 1;
      end else begin
        w_ready = ready_for(v.ready_mode, cyc);
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!last_hs) check({tag, "_timeout"}, cyc, -1);
    check({tag, "_first_valid"}, first_valid, 2);
    check({tag, "_beats"}, beats_seen, v.exp_beats);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
    w_ready = 1'b0;
  endtask

  initial begin
    int   cyc;
    bit   any_bad;
    vec_t v;

    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 29 + 7) ^ 8'hA5;

    //          base   in     neu    mode beats final
    vecs[0] = '{8'h10, 8'd3,  8'd2,  0,   6,    8'h15};
    vecs[1] = '{8'hFE, 8'd4,  8'd1,  0,   4,    8'h01};
    vecs[2] = '{8'h20, 8'd4,  8'd2,  1,   8,    8'h27};
    vecs[3] = '{8'h33, 8'd5,  8'd0,  0,   0,    8'h00};
    vecs[4] = '{8'hF0, 8'd5,  8'd7,  1,   35,   8'h12};
    vecs[5] = '{8'h00, 8'd1,  8'd3,  0,   3,    8'h02};
    vecs[6] = '{8'h44, 8'd0,  8'd3,  0,   0,    8'h00};

    // Reset state.
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(w_valid), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_data", 32'($unsigned(w_data)), 0);
    check("rst_tags", 32'({w_last_in, w_last}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) run_pass($sformatf("vec%0d", t), vecs[t]);

    // Abort after three beats, then a clean pass.
    v = '{8'h40, 8'd4, 8'd3, 0, 12, 8'h4B};
    load_expected(v);
    last_hs    = 0;
    beats_seen = 0;
    w_ready    = 1'b1;
    kick(v);
    cyc = 0;
    while (beats_seen < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach3", beats_seen, 3);
    abort   = 1'b1;
    w_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 32'(w_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    exp_q.delete();
    any_bad = 0;
    w_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done || w_valid || busy) any_bad = 1;
    end
    check("abort_quiet", 32'(any_bad), 0);
    check("abort_beats", beats_seen, 3);
    run_pass("post_abort", vecs[0]);

    // Reset mid-pass while stalled, then a clean pass.
    v = '{8'h80, 8'd4, 8'd2, 2, 8, 8'h87};
    load_expected(v);
    last_hs    = 0;
    beats_seen = 0;
    w_ready    = 1'b0;
    kick(v);
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_valid", 32'(w_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_valid", 32'(w_valid), 0);
    check("mid_rst_addr", 32'(rom_addr), 0);
    check("mid_rst_data", 32'($unsigned(w_data)), 0);
    check("mid_rst_tags", 32'({w_last_in, w_last}), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_beats", beats_seen, 0);
    run_pass("post_reset", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
